exec_ctrl: RTL and testbench
============================

# exec_ctrl

Execution sequencer for the single-cycle MIPS core. Turns three raw board buttons into run/step/halt control and drives one clock-enable, `cpu_en`, that gates the PC, register-file write and data-memory write. Adds a single PC breakpoint and stops on a decoded halt instruction. Keeps a retired-instruction counter for the seven-segment display path.

## Interface

Parameters:
- `PC_W`, 32, PC and breakpoint width
- `CNT_W`, 32, retired-counter width
- `DEBOUNCE_CYCLES`, 4, stable-sample count; used only with `EXEC_CTRL_DEBOUNCE_EN`

Ports:
- `clk`  in  1  core clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_run`  in  1  raw button, async to `clk`
- `btn_step`  in  1  raw button, async to `clk`
- `btn_halt`  in  1  raw button, async to `clk`
- `pc`  in  PC_W  current PC from the program counter
- `halt_insn`  in  1  decoder flag: the instruction at `pc` is halt/illegal
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint address
- `cpu_en`  out  1  datapath clock-enable, combinational from state and inputs
- `state`  out  2  HALT=00, RUN=01, STEP=10, BREAK=11
- `retired_cnt`  out  CNT_W  count of cycles with `cpu_en`=1
- `bp_hit`  out  1  registered; 1 while in BREAK

## Operation

- Each button passes through a 2-FF synchronizer, then a rising-edge detector. The result is one-cycle pulses `p_run`, `p_step`, `p_halt`.
- Pulse priority when pulses coincide: halt > step > run.
- `skip` flag:
  - Set on every transition into RUN or STEP.
  - Cleared after the first cycle with `cpu_en`=1.
  - Suppresses the breakpoint compare only, so a resumed program executes the instruction at the breakpoint.
- `bphit_c` = `bp_en` && (`pc` == `bp_addr`) && !`skip`.
- HALT:
  - `cpu_en`=0.
  - `p_step` → STEP.
  - `p_run` → RUN.
- RUN:
  - `cpu_en` = !`halt_insn` && !`bphit_c` && !`p_halt`.
  - `p_halt` → HALT.
  - Else `halt_insn` → HALT (the halt instruction is not executed).
  - Else `bphit_c` → BREAK.
  - Otherwise remain in RUN.
- STEP:
  - `cpu_en` = !`halt_insn` && !`p_halt`.
  - Always → HALT on the next edge. Exactly one instruction executes, or none if `halt_insn` or `p_halt`.
  - The breakpoint is ignored in STEP.
- BREAK:
  - `cpu_en`=0.
  - `p_step` → STEP.
  - `p_run` → RUN.
  - `p_halt` → HALT.
- `retired_cnt` increments on each edge where `cpu_en`=1 and saturates at all-ones.
- `bp_hit` = (next state == BREAK), registered.

## Timing

- Reset values (async assert, sync deassert is external):
  - state=HALT, `cpu_en`=0, `retired_cnt`=0, `bp_hit`=0, `skip`=0.
  - Synchronizer and edge registers are 0.
- Button latency without debounce: raw rise sampled at edge k → pulse asserted after edge k+2 → state changes at edge k+3.
- `cpu_en` is valid in the same cycle as the state, so the first enabled datapath edge is k+4.
- STEP produces exactly one `cpu_en` high cycle, then HALT.
- Reset mid-RUN: `cpu_en` drops immediately (asynchronously). The count is lost.
- A held button generates only one pulse. Re-arming requires a release (a 0 sample).

## Configuration

- `EXEC_CTRL_DEBOUNCE_EN` defined:
  - After the synchronizer, each button has a per-button counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal samples that differ from the current level.
  - The edge detector runs on the debounced level.
  - Latency grows by `DEBOUNCE_CYCLES`.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.
- Not defined: the edge detector runs directly on the synchronizer output, and `DEBOUNCE_CYCLES` is unused.

## Test plan

- Reset, then idle 10 cycles → state=00, `cpu_en`=0, `retired_cnt`=0.
- Pulse `btn_step` twice, with release in between → exactly two `cpu_en` high cycles, `retired_cnt`=2, state returns to 00 after each.
- Setup: `bp_en`=1, `bp_addr`=0x0000_0010, `pc` incrementing by 4 from 0 while `cpu_en`=1.
  - Press run → `retired_cnt`=4, state=11, `bp_hit`=1, `pc` holds 0x10.
  - Press run again → the 0x10 instruction executes, and RUN continues past it.
- In RUN, assert `halt_insn` at `pc`=0x08 → `cpu_en`=0 in that cycle, state=00 on the next edge, `retired_cnt`=2.
- Simultaneous run+step press in HALT → STEP taken: one instruction, then state=00.
- Glitch and mid-operation reset:
  - With `EXEC_CTRL_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=4, a 3-cycle `btn_run` glitch → no state change.
  - Assert `rst_n`=0 mid-RUN → `cpu_en`=0 immediately and `retired_cnt`=0.

Source files
------------

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exec_ctrl
//  Purpose  : Run/step/halt execution sequencer for the single-cycle MIPS
//             core. Synchronizes three raw buttons into one-cycle pulses,
//             drives the datapath clock-enable cpu_en, supports a single PC
//             breakpoint, stops on a decoded halt instruction and counts
//             retired instructions.
//  Options  : EXEC_CTRL_DEBOUNCE_EN - adds a DEBOUNCE_CYCLES stable-sample
//             debouncer on every button after the synchronizer.
//  Revision : 1.0 - initial release
// ============================================================================
module exec_ctrl #(
  parameter int PC_W            = 32,
  parameter int CNT_W           = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_halt,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_insn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             bp_hit
);

  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef EXEC_CTRL_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // Bit order for all button vectors: [2]=halt, [1]=step, [0]=run
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] btn_lvl;
  logic [2:0] lvl_prev;
  logic [2:0] pulse;

  logic       p_run;
  logic       p_step;
  logic       p_halt;

  logic [1:0] cur_state;
  logic [1:0] nxt_state;
  logic       skip;
  logic       bphit_c;

  assign btn_raw = {btn_halt, btn_step, btn_run};

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  generate
    if (DB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
      localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

      for (genvar i = 0; i < 3; i++) begin : g_btn
        logic [DB_W-1:0] cnt;
        logic            lvl;

        // Level flips only after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt <= '0;
            lvl <= 1'b0;
          end else if (sync2[i] == lvl) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt <= '0;
            lvl <= sync2[i];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        assign btn_lvl[i] = lvl;
      end
    end else begin : g_raw
      assign btn_lvl = sync2;
    end
  endgenerate

  // Registered rising-edge detector; a held button yields a single pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev <= 3'b000;
      pulse    <= 3'b000;
    end else begin
      lvl_prev <= btn_lvl;
      pulse    <= btn_lvl & ~lvl_prev;
    end
  end

  assign p_run  = pulse[0];
  assign p_step = pulse[1];
  assign p_halt = pulse[2];

  // Breakpoint compare is masked for the first executed instruction after resume
  assign bphit_c = bp_en && (pc == bp_addr) && !skip;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_HALT;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; coincident pulses resolve halt > step > run
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_HALT: begin
        if (p_halt) begin
          nxt_state = S_HALT;
        end else if (p_step) begin
          nxt_state = S_STEP;
        end else if (p_run) begin
          nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        if (p_halt || halt_insn) begin
          nxt_state = S_HALT;
        end else if (bphit_c) begin
          nxt_state = S_BREAK;
        end
      end
      S_STEP: begin
        nxt_state = S_HALT;
      end
      S_BREAK: begin
        if (p_halt) begin
          nxt_state = S_HALT;
        end else if (p_step) begin
          nxt_state = S_STEP;
        end else if (p_run) begin
          nxt_state = S_RUN;
        end
      end
      default: begin
        nxt_state = S_HALT;
      end
    endcase
  end

  // Output logic: datapath enable valid in the same cycle as the state
  always_comb begin
    cpu_en = 1'b0;
    case (cur_state)
      S_RUN:   cpu_en = !halt_insn && !bphit_c && !p_halt;
      S_STEP:  cpu_en = !halt_insn && !p_halt;
      default: cpu_en = 1'b0;
    endcase
  end

  // Skip flag: armed on entry to RUN/STEP, dropped after first enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= 1'b0;
    end else if ((nxt_state != cur_state) &&
                 ((nxt_state == S_RUN) || (nxt_state == S_STEP))) begin
      skip <= 1'b1;
    end else if (cpu_en) begin
      skip <= 1'b0;
    end
  end

  // Breakpoint indicator tracks the registered BREAK state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= (nxt_state == S_BREAK);
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (cpu_en && (retired_cnt != CNT_MAX)) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_ctrl
//  Purpose  : Scoreboard bench for exec_ctrl: reset, step, breakpoint,
//             halt instruction, pulse priority and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl;

  localparam int PC_W = 32;
  localparam int CNT_W = 32;
  localparam int DEB = 4;
`ifdef EXEC_CTRL_DEBOUNCE_EN
  localparam int LAT_EXTRA = DEB;
`else
  localparam int LAT_EXTRA = 0;
`endif
  localparam int HOLD = DEB + 4;

  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  logic             clk;
  logic             rst_n;
  logic             btn_run;
  logic             btn_step;
  logic             btn_halt;
  logic [PC_W-1:0]  pc;
  logic             halt_insn;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] retired_cnt;
  logic             bp_hit;

  logic             halt_arm;
  logic [PC_W-1:0]  halt_addr;

  int checks = 0;
  int failures = 0;
  int en_total = 0;
  logic [31:0] exp_q[$];

  exec_ctrl #(
    .PC_W(PC_W),
    .CNT_W(CNT_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_halt(btn_halt),
    .pc(pc),
    .halt_insn(halt_insn),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .cpu_en(cpu_en),
    .state(state),
    .retired_cnt(retired_cnt),
    .bp_hit(bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program-counter model: advances by 4 on every enabled edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign halt_insn = halt_arm && (pc == halt_addr);

  // Independent count of enabled cycles
  always @(negedge clk) begin
    if (cpu_en) en_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    btn_halt = 1'b0;
    bp_en = 1'b0;
    bp_addr = '0;
    halt_arm = 1'b0;
    halt_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic r, input logic s, input logic h);
    @(negedge clk);
    btn_run = r;
    btn_step = s;
    btn_halt = h;
    fork
      begin
        repeat (HOLD) @(negedge clk);
        btn_run = 1'b0;
        btn_step = 1'b0;
        btn_halt = 1'b0;
      end
    join_none
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic settle();
    repeat (HOLD + 4) @(negedge clk);
  endtask

  initial begin
    int base;
    int lat;
    int n;

    do_reset();

    // Reset and idle
    push(0); push(0); push(0); push(0);
    repeat (10) @(negedge clk);
    sb_check("rst_state", 32'(state));
    sb_check("rst_en", 32'(cpu_en));
    sb_check("rst_cnt", retired_cnt);
    sb_check("rst_bphit", 32'(bp_hit));

    // Single step twice, with latency measurement on the first press
    base = en_total;
    push(4 + LAT_EXTRA); push(1);
    press(1'b0, 1'b1, 1'b0);
    lat = 0;
    while (state !== S_STEP && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    sb_check("step_lat", 32'(lat));
    sb_check("step_en", 32'(cpu_en));
    wait_state(S_HALT, 5, "step1_halt");
    settle();
    push(1);
    sb_check("step1_cnt", 32'(en_total - base));
    press(1'b0, 1'b1, 1'b0);
    wait_state(S_STEP, 30, "step2_enter");
    wait_state(S_HALT, 5, "step2_halt");
    settle();
    push(2); push(2); push(32'h8);
    sb_check("step2_en", 32'(en_total - base));
    sb_check("step2_cnt", retired_cnt);
    sb_check("step2_pc", pc);

    // Breakpoint at 0x10, then resume past it
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    push(1); push(4); push(32'h10); push(32'h10); push(32'(S_BREAK));
    press(1'b1, 1'b0, 1'b0);
    wait_state(S_BREAK, 40, "bp_reach");
    sb_check("bp_hit", 32'(bp_hit));
    sb_check("bp_cnt", retired_cnt);
    sb_check("bp_pc", pc);
    settle();
    sb_check("bp_hold_pc", pc);
    sb_check("bp_hold_state", 32'(state));
    push(32'(S_RUN)); push(6);
    press(1'b1, 1'b0, 1'b0);
    n = 0;
    while (pc !== 32'h18 && n < 40) begin
      @(negedge clk);
      n++;
    end
    sb_check("resume_state", 32'(state));
    sb_check("resume_cnt", retired_cnt);
    push(0);
    press(1'b0, 1'b0, 1'b1);
    wait_state(S_HALT, 30, "bp_halt_btn");
    sb_check("bp_hit_clr", 32'(bp_hit));
    settle();

    // Halt instruction at 0x08 stops RUN without executing it
    do_reset();
    halt_arm = 1'b1;
    halt_addr = 32'h8;
    push(0); push(32'(S_RUN)); push(32'(S_HALT)); push(2);
    press(1'b1, 1'b0, 1'b0);
    n = 0;
    while (pc !== 32'h8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    sb_check("hi_en", 32'(cpu_en));
    sb_check("hi_state_run", 32'(state));
    @(negedge clk);
    sb_check("hi_state_halt", 32'(state));
    sb_check("hi_cnt", retired_cnt);
    settle();
    halt_arm = 1'b0;

    // Run+step together: step wins
    do_reset();
    base = en_total;
    press(1'b1, 1'b1, 1'b0);
    wait_state(S_STEP, 30, "sim_step");
    wait_state(S_HALT, 5, "sim_halt");
    settle();
    push(1); push(1);
    sb_check("sim_en", 32'(en_total - base));
    sb_check("sim_cnt", retired_cnt);

    // Halt+run together: halt wins, nothing executes
    push(32'(S_HALT)); push(1);
    press(1'b1, 1'b0, 1'b1);
    repeat (HOLD + 10) @(negedge clk);
    sb_check("hr_state", 32'(state));
    sb_check("hr_cnt", retired_cnt);

`ifdef EXEC_CTRL_DEBOUNCE_EN
    // Short glitch is filtered by the debouncer
    push(32'(S_HALT)); push(1);
    @(negedge clk);
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
    repeat (20) @(negedge clk);
    sb_check("glitch_state", 32'(state));
    sb_check("glitch_cnt", retired_cnt);
`endif

    // Asynchronous reset in the middle of RUN
    do_reset();
    push(5); push(0); push(0); push(32'(S_HALT));
    press(1'b1, 1'b0, 1'b0);
    wait_state(S_RUN, 30, "mr_run");
    repeat (5) @(negedge clk);
    sb_check("mr_cnt_pre", retired_cnt);
    #2 rst_n = 1'b0;
    #1;
    sb_check("mr_en", 32'(cpu_en));
    sb_check("mr_cnt", retired_cnt);
    sb_check("mr_state", 32'(state));
    settle();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
